// File: rtl/tile_blit_pkg.sv
// Shared types and constants for the tile blitter: FSM states, tile sizes,
// address widths, the latched request record and the sprite ROM address helper.
package tile_blit_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } blit_state_e;

  localparam int unsigned TILE_SMALL = 8;
  localparam int unsigned TILE_LARGE = 16;
  localparam int unsigned FB_AW      = 16;
  localparam int unsigned ROM_AW     = 14;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned SCR_W      = 8;
  localparam int unsigned SHEET_W    = 7;

  typedef struct packed {
    logic [SCR_W-1:0]   draw_x;
    logic [SCR_W-1:0]   draw_y;
    logic [SHEET_W-1:0] sprite_x;
    logic [SHEET_W-1:0] sprite_y;
    logic               is_8;
  } tile_req_t;

  // Sprite-sheet coordinates wrap modulo 128 in both axes.
  function automatic logic [ROM_AW-1:0] rom_addr_f(
    input logic [SHEET_W-1:0] sx,
    input logic [SHEET_W-1:0] sy,
    input logic [CNT_W-1:0]   row,
    input logic [CNT_W-1:0]   col
  );
    logic [SHEET_W-1:0] ax;
    logic [SHEET_W-1:0] ay;
    ax = sx + SHEET_W'(col);
    ay = sy + SHEET_W'(row);
    return {ay, ax};
  endfunction

endpackage

// File: rtl/tile_scan_counter.sv
// Row-major row/col scan counter for 8x8 or 16x16 tiles, with clear,
// advance, look-ahead next position and a last-pixel flag.
module tile_scan_counter
  import tile_blit_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic             is_8_i,
  output logic [CNT_W-1:0] row_o,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] row_nxt_c,
  output logic [CNT_W-1:0] col_nxt_c,
  output logic             last_c
);

  logic [CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] max_c;
  logic             col_end_c;

  always_comb begin
    max_c     = is_8_i ? CNT_W'(TILE_SMALL - 1) : CNT_W'(TILE_LARGE - 1);
    col_end_c = (col_q == max_c);
    last_c    = col_end_c && (row_q == max_c);
    col_d     = col_end_c ? '0 : col_q + CNT_W'(1);
    row_d     = col_end_c ? row_q + CNT_W'(1) : row_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (adv_i) begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o     = row_q;
  assign col_o     = col_q;
  assign row_nxt_c = row_d;
  assign col_nxt_c = col_d;

endmodule

// File: rtl/tile_blitter.sv
// Copies one 8x8/16x16 tile from the sprite ROM into the framebuffer, one pixel
// per cycle, with four-phase completion. Option: TILE_BLIT_TRANSPARENCY_EN.
module tile_blitter
  import tile_blit_pkg::*;
#(
  parameter int unsigned PIX_W = 4
) (
  input  logic               Clk,
  input  logic               RESET,
  input  logic               Draw_FB_EN,
  input  logic [SCR_W-1:0]   NewDrawX,
  input  logic [SCR_W-1:0]   NewDrawY,
  input  logic [SHEET_W-1:0] NewSpriteX,
  input  logic [SHEET_W-1:0] NewSpriteY,
  input  logic               is_8,
  output logic               Done_Draw_FB,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [PIX_W-1:0]   rom_data,
  output logic               fb_we,
  output logic [FB_AW-1:0]   fb_addr,
  output logic [PIX_W-1:0]   fb_data
);

  blit_state_e       state_q;
  tile_req_t         req_q;
  logic [ROM_AW-1:0] rom_addr_q;
  logic [FB_AW-1:0]  fb_addr_q;
  logic              wr_q;
  logic              done_q;

  logic [CNT_W-1:0]  row_c, col_c, row_nxt_c, col_nxt_c;
  logic              last_c;
  logic [SCR_W:0]    sum_x_c, sum_y_c;
  logic              in_bounds_c;
  logic              pix_keep_c;

  tile_scan_counter u_scan (
    .clk_i     (Clk),
    .rst_i     (RESET),
    .clr_i     (state_q == IDLE),
    .adv_i     (state_q == RUN),
    .is_8_i    (req_q.is_8),
    .row_o     (row_c),
    .col_o     (col_c),
    .row_nxt_c (row_nxt_c),
    .col_nxt_c (col_nxt_c),
    .last_c    (last_c)
  );

  // Screen position of the pixel being issued; off-screen pixels are clipped.
  always_comb begin
    sum_x_c     = (SCR_W+1)'(req_q.draw_x) + (SCR_W+1)'(col_c);
    sum_y_c     = (SCR_W+1)'(req_q.draw_y) + (SCR_W+1)'(row_c);
    in_bounds_c = !sum_x_c[SCR_W] && !sum_y_c[SCR_W];
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state_q    <= IDLE;
      req_q      <= '0;
      rom_addr_q <= '0;
      fb_addr_q  <= '0;
      wr_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Draw_FB_EN) begin
            state_q    <= RUN;
            req_q      <= '{draw_x: NewDrawX, draw_y: NewDrawY,
                            sprite_x: NewSpriteX, sprite_y: NewSpriteY, is_8: is_8};
            rom_addr_q <= rom_addr_f(NewSpriteX, NewSpriteY, '0, '0);
          end
        end
        RUN: begin
          // ROM data for this pixel arrives next cycle, together with the write.
          wr_q      <= in_bounds_c;
          fb_addr_q <= {sum_y_c[SCR_W-1:0], sum_x_c[SCR_W-1:0]};
          if (last_c) begin
            state_q <= FLUSH;
          end else begin
            rom_addr_q <= rom_addr_f(req_q.sprite_x, req_q.sprite_y, row_nxt_c, col_nxt_c);
          end
        end
        FLUSH: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: begin
          if (!Draw_FB_EN) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef TILE_BLIT_TRANSPARENCY_EN
  assign pix_keep_c = (rom_data != '0);
`else
  assign pix_keep_c = 1'b1;
`endif

  assign Done_Draw_FB = done_q;
  assign rom_addr     = rom_addr_q;
  assign fb_addr      = fb_addr_q;
  assign fb_we        = wr_q && pix_keep_c;
  assign fb_data      = fb_we ? rom_data : '0;

endmodule

// File: tb/tb_tile_blitter.sv
// Directed table-driven bench for tile_blitter: clipping, sprite wrap, latency,
// handshake, latched request, mid-tile reset and optional transparency.
module tb_tile_blitter;

`ifdef TILE_BLIT_TRANSPARENCY_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        RESET = 1'b1;
  logic        Draw_FB_EN = 1'b0;
  logic [7:0]  NewDrawX = '0;
  logic [7:0]  NewDrawY = '0;
  logic [6:0]  NewSpriteX = '0;
  logic [6:0]  NewSpriteY = '0;
  logic        is_8 = 1'b0;
  logic        Done_Draw_FB;
  logic [13:0] rom_addr;
  logic [3:0]  rom_data = '0;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [3:0]  fb_data;

  int checks = 0;
  int failures = 0;

  logic [15:0] wq_addr[$];
  logic [3:0]  wq_data[$];

  tile_blitter #(.PIX_W(4)) dut (
    .Clk          (Clk),
    .RESET        (RESET),
    .Draw_FB_EN   (Draw_FB_EN),
    .NewDrawX     (NewDrawX),
    .NewDrawY     (NewDrawY),
    .NewSpriteX   (NewSpriteX),
    .NewSpriteY   (NewSpriteY),
    .is_8         (is_8),
    .Done_Draw_FB (Done_Draw_FB),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_data      (fb_data)
  );

  always #5 Clk = ~Clk;

  // Synchronous sprite ROM: odd sheet columns return their low nibble, even ones 0.
  always @(posedge Clk) rom_data <= rom_addr[0] ? rom_addr[3:0] : 4'd0;

  always @(negedge Clk) begin
    if (fb_we) begin
      wq_addr.push_back(fb_addr);
      wq_data.push_back(fb_data);
    end
  end

  typedef struct {
    logic [7:0]  dx;
    logic [7:0]  dy;
    logic [6:0]  sx;
    logic [6:0]  sy;
    logic        is8;
    int          exp_writes;
    int          done_cyc;
    logic [15:0] first;
    logic [15:0] last;
  } vec_t;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t vecs[4];

  initial begin
    vec_t t;
    int   n, edges, start, nw, bad, row, col, sxc, expd;
    bit   seen, held_ok, done_ok;
    logic [7:0] x, y;

    vecs[0] = '{8'h10, 8'h20, 7'd8,   7'd16, 1'b1, TR ? 32  : 64,  66,  TR ? 16'h2011 : 16'h2010, 16'h2717};
    vecs[1] = '{8'hF8, 8'h00, 7'd0,   7'd0,  1'b0, TR ? 64  : 128, 258, TR ? 16'h00F9 : 16'h00F8, 16'h0FFF};
    vecs[2] = '{8'h40, 8'hFC, 7'd124, 7'd126,1'b1, TR ? 16  : 32,  66,  TR ? 16'hFC41 : 16'hFC40, 16'hFF47};
    vecs[3] = '{8'h30, 8'h50, 7'd121, 7'd0,  1'b0, TR ? 128 : 256, 258, 16'h5030, TR ? 16'h5F3E : 16'h5F3F};

    // Reset state
    repeat (3) tick();
    chk("rst_done", 32'(Done_Draw_FB), 32'd0);
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_data", 32'(fb_data), 32'd0);
    RESET = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      t = vecs[v];
      n = t.is8 ? 8 : 16;
      NewDrawX = t.dx; NewDrawY = t.dy; NewSpriteX = t.sx; NewSpriteY = t.sy; is_8 = t.is8;
      Draw_FB_EN = 1'b1;
      start = wq_addr.size();
      seen = 1'b0;
      edges = 0;
      while (!seen && edges < 400) begin
        tick();
        edges++;
        if (edges == 5) begin
          // Request inputs change mid-tile; only the latched values may matter.
          NewDrawX = ~t.dx; NewDrawY = ~t.dy; NewSpriteX = ~t.sx;
          NewSpriteY = t.sy + 7'd33; is_8 = ~t.is8;
        end
        if (Done_Draw_FB) seen = 1'b1;
      end
      chk($sformatf("v%0d_done_cycle", v), 32'(edges), 32'(t.done_cyc));

      nw = wq_addr.size() - start;
      chk($sformatf("v%0d_writes", v), 32'(nw), 32'(t.exp_writes));
      if (nw > 0) begin
        chk($sformatf("v%0d_first", v), 32'(wq_addr[start]), 32'(t.first));
        chk($sformatf("v%0d_last", v), 32'(wq_addr[wq_addr.size()-1]), 32'(t.last));
      end else begin
        chk($sformatf("v%0d_any_write", v), 32'(nw), 32'(t.exp_writes));
      end

      bad = 0;
      for (int i = start; i < wq_addr.size(); i++) begin
        x = wq_addr[i][7:0];
        y = wq_addr[i][15:8];
        row = int'(y) - int'(t.dy);
        col = int'(x) - int'(t.dx);
        if (i > start && wq_addr[i] <= wq_addr[i-1]) bad++;
        if (row < 0 || row >= n || col < 0 || col >= n) begin
          bad++;
        end else begin
          sxc = (int'(t.sx) + col) & 127;
          expd = (sxc & 1) ? (sxc & 15) : 0;
          if (int'(wq_data[i]) != expd) bad++;
          if (TR && expd == 0) bad++;
        end
      end
      chk($sformatf("v%0d_bad_writes", v), 32'(bad), 32'd0);

      // EN held high past Done: no restart
      held_ok = 1'b1;
      repeat (10) begin
        tick();
        if (!Done_Draw_FB) held_ok = 1'b0;
      end
      chk($sformatf("v%0d_done_held", v), 32'(held_ok), 32'd1);
      chk($sformatf("v%0d_no_restart", v), 32'(wq_addr.size() - start), 32'(nw));

      Draw_FB_EN = 1'b0;
      tick();
      chk($sformatf("v%0d_done_fall", v), 32'(Done_Draw_FB), 32'd0);
    end

    // Reset in cycle 30 of a 16x16 tile
    NewDrawX = 8'h00; NewDrawY = 8'h00; NewSpriteX = 7'd1; NewSpriteY = 7'd0; is_8 = 1'b0;
    Draw_FB_EN = 1'b1;
    repeat (30) tick();
    chk("mid_rst_writing", 32'(fb_we), 32'd1);
    RESET = 1'b1;
    Draw_FB_EN = 1'b0;
    tick();
    chk("mid_rst_fb_we", 32'(fb_we), 32'd0);
    chk("mid_rst_done", 32'(Done_Draw_FB), 32'd0);
    chk("mid_rst_rom_addr", 32'(rom_addr), 32'd0);
    RESET = 1'b0;
    start = wq_addr.size();
    done_ok = 1'b1;
    repeat (300) begin
      tick();
      if (Done_Draw_FB) done_ok = 1'b0;
    end
    chk("post_rst_writes", 32'(wq_addr.size() - start), 32'd0);
    chk("post_rst_no_done", 32'(done_ok), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tile_blitter.md
# tile_blitter

Framebuffer write stage directly downstream of the room drawer. Accepts one tile request (screen position, sprite-sheet position, tile size), copies the 8x8 or 16x16 tile from the synchronous sprite ROM into framebuffer SRAM one pixel per cycle, then signals completion via a four-phase handshake. One request at a time; requests arriving while busy are not accepted.

## Interface
Parameters:
- `PIX_W`, 4: palette-index width per pixel.

Ports:
- `Clk`  in  1  system clock. All logic is on its rising edge.
- `RESET`  in  1  reset, synchronous and active-high.
- `Draw_FB_EN`  in  1  request. Held high until `Done_Draw_FB` is seen, then dropped.
- `NewDrawX`, `NewDrawY`  in  8 each  screen coordinates of the tile's top-left pixel. Framebuffer is 256x256.
- `NewSpriteX`, `NewSpriteY`  in  7 each  sprite-sheet coordinates of the tile's top-left pixel. Sheet is 128x128.
- `is_8`  in  1  tile size: 1 = 8x8, 0 = 16x16.
- `Done_Draw_FB`  out  1  completion flag for the four-phase handshake.
- `rom_addr`  out  14  sprite ROM address {sy, sx}. ROM data returns one cycle later.
- `rom_data`  in  PIX_W  sprite ROM read data.
- `fb_we`  out  1  framebuffer write strobe.
- `fb_addr`  out  16  framebuffer address {y, x}.
- `fb_data`  out  PIX_W  framebuffer write data.

## Operation
- Request fields (`NewDrawX/Y`, `NewSpriteX/Y`, `is_8`) are latched on acceptance. Later input changes have no effect on the current tile.
- Tile size N is 8 if `is_8` is 1, otherwise 16. Scan order is row-major: col 0..N-1 within row 0..N-1.
- State machine (registered state):
  - IDLE → RUN when `Draw_FB_EN`=1; latch the request and clear row/col.
  - RUN: drive `rom_addr` = {(SpriteY+row) mod 128, (SpriteX+col) mod 128} and advance col, then row. After issuing the last pixel (row=col=N-1), go to FLUSH.
  - FLUSH: one cycle; the write of the last pixel completes. Then → DONE.
  - DONE: `Done_Draw_FB`=1. Stay until `Draw_FB_EN`=0, then → IDLE.
- Write pipeline: the pixel whose ROM address is issued in cycle k is written in cycle k+1.
  - `fb_addr` = {DrawY+row, DrawX+col}, using row/col delayed by one cycle.
  - Sums are 9 bits wide. If either sum is >255, that pixel is clipped: `fb_we`=0. There is no wrap-around on screen.
- `fb_we` is 0 in every cycle that does not carry a valid pixel write.
- `Draw_FB_EN` is ignored in RUN and FLUSH.

## Timing
- Reset values: state IDLE, `Done_Draw_FB`=0, `fb_we`=0, `rom_addr`=0, `fb_addr`=0, `fb_data`=0.
- Accepting edge at cycle 0:
  - RUN occupies cycles 1..N².
  - FLUSH occurs at cycle N²+1.
  - `Done_Draw_FB`=1 from cycle N²+2.
  - Writes occur in cycles 2..N²+1.
  - Resulting latencies: 8x8 → Done at cycle 66; 16x16 → Done at cycle 258.
- `Done_Draw_FB` goes low the cycle after `Draw_FB_EN` is seen low in DONE. The earliest next acceptance is one cycle after that.
- `RESET` mid-operation: the next cycle is IDLE with `fb_we`=0. No further writes occur and no Done is issued.

## Configuration
- `TILE_BLIT_TRANSPARENCY_EN` defined: a pixel with `rom_data`==0 is transparent. `fb_we` is suppressed for it; the background is kept.
- Not defined: all in-bounds pixels are written, including index 0.
- Cycle timing is identical in both builds.

## Structure
- Package `tile_blit_pkg` holds:
  - state enum (IDLE, RUN, FLUSH, DONE);
  - `TILE_SMALL`=8 and `TILE_LARGE`=16;
  - address-width constants `FB_AW`=16 and `ROM_AW`=14.
- Sub-module `tile_scan_counter` provides the row/col counter with size select, clear, advance, and last-pixel flag.

## Test plan
- 8x8 tile: DrawX=0x10, DrawY=0x20, SpriteX=8, SpriteY=16, ROM data = (addr & 0xF) → exactly 64 writes, with the first at fb_addr 0x2010 and the last at 0x2717. Done is high at cycle 66.
- 16x16 tile: DrawX=0xF8, DrawY=0 → only cols 0..7 are written. That is 128 writes, none with x<0xF8. Done is still at cycle 258.
- Handshake: hold `Draw_FB_EN` high 10 cycles past Done → no restart. Drop it → Done falls next cycle. A new request is then accepted.
- Change request inputs mid-RUN → addresses follow the latched values only.
- Assert `RESET` at cycle 30 of a 16x16 tile → `fb_we`=0 from the next cycle. State returns to IDLE and Done stays 0.
- With `TILE_BLIT_TRANSPARENCY_EN`, ROM returns 0 for even columns → only the 32 odd-column pixels of an 8x8 tile are written.
